// File: rtl/elevator_pkg.sv
// Shared elevator-panel definitions: keypad column strobes, debounce states and floor key codes.
package elevator_pkg;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    PRESSED = 2'd2
  } deb_state_e;

  // Key codes are {col_idx, row_idx}; the floor buttons occupy column 0.
  localparam logic [3:0] KEY_FLOOR_G = 4'h0;
  localparam logic [3:0] KEY_FLOOR_1 = 4'h1;
  localparam logic [3:0] KEY_FLOOR_2 = 4'h2;
  localparam logic [3:0] KEY_FLOOR_3 = 4'h3;

  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    logic [3:0] strobe;
    case (idx)
      2'd0:    strobe = COL0;
      2'd1:    strobe = COL1;
      2'd2:    strobe = COL2;
      2'd3:    strobe = COL3;
      default: strobe = COL0;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/keypad_scan_sync_2ff.sv
// sync_2ff: 4-bit two-flop synchronizer for the asynchronous keypad row returns (idle high).
module sync_2ff (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_r;
  logic [3:0] sync_r;

  // Two-stage capture; resets to the released (pulled-up) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 4'b1111;
      sync_r <= 4'b1111;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix scanner with per-frame debounce and ghost rejection.
// Auto-repeat of a held key is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scan
  import elevator_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kpd_row,
  output logic [3:0] kpd_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  if (SCAN_DIV < 3 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scan: parameter out of range");
  end

  logic [3:0]       row_sync_s;
  logic [DIV_W-1:0] div_cnt_r;
  logic [1:0]       col_idx_r;
  logic [3:0]       kpd_col_r;
  logic [11:0]      press_r;
  logic [15:0]      pressed_s;
  logic [4:0]       ones_s;
  logic [3:0]       key_s;
  logic             key_hit_s;
  logic             sample_s;
  logic             eval_s;
  deb_state_e       state_r;
  logic [3:0]       cand_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] rel_cnt_r;
  logic [3:0]       key_code_r;
  logic             key_valid_r;
  logic             key_held_r;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_cnt_r;
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kpd_row),
    .q   (row_sync_s)
  );

  assign sample_s = (div_cnt_r == DIV_LAST);
  assign eval_s   = sample_s && (col_idx_r == 2'd3);

  // Dwell counter, column rotation and per-column snapshot of pressed rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
      col_idx_r <= 2'd0;
      kpd_col_r <= COL0;
      press_r   <= 12'd0;
    end else if (sample_s) begin
      div_cnt_r <= '0;
      col_idx_r <= col_idx_r + 2'd1;
      kpd_col_r <= col_strobe(col_idx_r + 2'd1);
      case (col_idx_r)
        2'd0:    press_r[3:0]  <= ~row_sync_s;
        2'd1:    press_r[7:4]  <= ~row_sync_s;
        2'd2:    press_r[11:8] <= ~row_sync_s;
        default: press_r       <= press_r;  // column 3 is used live at evaluation
      endcase
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Flatten the frame (bit index == key code) and classify it: none, one key, or ghosted.
  always_comb begin
    pressed_s = {~row_sync_s, press_r};
    ones_s    = 5'd0;
    key_s     = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pressed_s[i]) begin
        ones_s = ones_s + 5'd1;
        key_s  = 4'(i);
      end else begin
        ones_s = ones_s;
        key_s  = key_s;
      end
    end
    key_hit_s = (ones_s == 5'd1);
  end

  // Debounce state machine, stepped once per frame evaluation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cand_r      <= 4'd0;
      cnt_r       <= '0;
      rel_cnt_r   <= '0;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_r   <= '0;
`endif
    end else begin
      key_valid_r <= 1'b0;
      if (eval_s) begin
        case (state_r)
          IDLE: begin
            if (key_hit_s && (DEBOUNCE_SCANS == 1)) begin
              state_r     <= PRESSED;
              key_code_r  <= key_s;
              key_valid_r <= 1'b1;
              key_held_r  <= 1'b1;
              rel_cnt_r   <= '0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_r   <= '0;
`endif
            end else if (key_hit_s) begin
              state_r <= CAND;
              cand_r  <= key_s;
              cnt_r   <= CNT_W'(1);
            end
          end
          CAND: begin
            if (!key_hit_s) begin
              state_r <= IDLE;
              cnt_r   <= '0;
            end else if (key_s != cand_r) begin
              cand_r <= key_s;
              cnt_r  <= CNT_W'(1);
            end else if (cnt_r == DEB_LAST) begin
              state_r     <= PRESSED;
              cnt_r       <= '0;
              key_code_r  <= key_s;
              key_valid_r <= 1'b1;
              key_held_r  <= 1'b1;
              rel_cnt_r   <= '0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_r   <= '0;
`endif
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (key_hit_s && (key_s == key_code_r)) begin
              rel_cnt_r <= '0;
`ifdef KEYPAD_REPEAT_EN
              if (rel_cnt_r != '0) begin
                rep_cnt_r <= '0;
              end else if (rep_cnt_r == REP_LAST) begin
                rep_cnt_r   <= '0;
                key_valid_r <= 1'b1;
              end else begin
                rep_cnt_r <= rep_cnt_r + REP_W'(1);
              end
`endif
            end else if (rel_cnt_r == DEB_LAST) begin
              state_r    <= IDLE;
              key_held_r <= 1'b0;
              rel_cnt_r  <= '0;
            end else begin
              rel_cnt_r <= rel_cnt_r + CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_r <= '0;
`endif
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign kpd_col   = kpd_col_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle frames).
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  kpd_row;
  logic [3:0]  kpd_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int          cyc = 0;
  int          vcount = 0;
  int          first_cyc = 0;
  int          second_cyc = 0;
  logic [3:0]  last_code = 4'h0;
  logic        held_seen = 1'b0;
  int          checks = 0;
  int          errors = 0;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_PULSES = 4;
`else
  localparam int REP_PULSES = 1;
`endif

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          pulses;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[4];

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2),
    .REPEAT_SCANS   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kpd_row   (kpd_row),
    .kpd_col   (kpd_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Switch matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    kpd_row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !kpd_col[c]) kpd_row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      if (vcount == 0) first_cyc = cyc;
      else if (vcount == 1) second_cyc = cyc;
      vcount++;
      last_code = key_code;
    end
    if (key_held) held_seen = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_col;
    int c0;

    vecs[0] = '{keys: 16'h0200, hold: 200, pulses: 1,          code: 4'h9};
    vecs[1] = '{keys: 16'h0021, hold: 200, pulses: 0,          code: 4'h0};
    vecs[2] = '{keys: 16'h0040, hold: 10,  pulses: 0,          code: 4'h0};
    vecs[3] = '{keys: 16'h8000, hold: 200, pulses: REP_PULSES, code: 4'hF};

    do_reset();
    check("rst_kpd_col", int'(kpd_col), int'(4'b1110));
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    vcount = 0;

    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      exp_col = 4'b0001 << ((k / 4) % 4);
      exp_col = ~exp_col;
      check($sformatf("rotate_%0d", k), int'(kpd_col), int'(exp_col));
    end
    #1;
    check("idle_no_valid", vcount, 0);

    for (int i = 0; i < 4; i++) begin
      vcount    = 0;
      held_seen = 1'b0;
      c0        = cyc;
      keys      = vecs[i].keys;
      run(vecs[i].hold);
      keys = 16'h0000;
      run(10);
      check($sformatf("v%0d_held_after_release", i), int'(key_held), (vecs[i].pulses > 0) ? 1 : 0);
      run(50);
      check($sformatf("v%0d_pulses", i), vcount, vecs[i].pulses);
      check($sformatf("v%0d_held_seen", i), int'(held_seen), (vecs[i].pulses > 0) ? 1 : 0);
      check($sformatf("v%0d_held_released", i), int'(key_held), 0);
      if (vecs[i].pulses > 0) begin
        check($sformatf("v%0d_code", i), int'(last_code), int'(vecs[i].code));
        check($sformatf("v%0d_latency_le_51", i), int'((first_cyc - c0) <= 51), 1);
      end
`ifdef KEYPAD_REPEAT_EN
      if (vecs[i].pulses > 1) check($sformatf("v%0d_repeat_gap", i), second_cyc - first_cyc, 48);
`endif
    end

    // Bounce on key 0, then a stable hold.
    vcount = 0;
    for (int t = 0; t < 12; t++) begin
      keys[0] = ~keys[0];
      run(5);
    end
    keys = 16'h0001;
    run(140);
    check("bounce_pulses", vcount, 1);
    check("bounce_code", int'(last_code), 0);
    check("bounce_held", int'(key_held), 1);
    keys = 16'h0000;
    run(60);
    check("bounce_released", int'(key_held), 0);

    // Reset while key 3 sits in CAND: no pulse, then a full re-debounce.
    keys = 16'h0008;
    do_reset();
    vcount = 0;
    run(24);
    check("cand_no_pulse_yet", vcount, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_kpd_col", int'(kpd_col), int'(4'b1110));
    check("midrst_key_valid", int'(key_valid), 0);
    check("midrst_key_held", int'(key_held), 0);
    rst = 1'b0;
    c0 = cyc;
    run(40);
    check("midrst_pulses", vcount, 1);
    check("midrst_latency", first_cyc - c0, 32);
    check("midrst_code", int'(last_code), 3);
    keys = 16'h0000;
    run(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
